regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port integer register file for the ID stage. It provides a configurable number of read and write ports, writeback-to-read bypass and a hardwired zero register. A per-register pending-write scoreboard lets the decode stage detect operands whose producer has not yet written back. It succeeds the single-write, two-read register file and serves both the scalar and dual-issue pipeline configurations.

## Interface
- XLEN, 32, data width of each register
- NREGS, 32, number of architectural registers (power of two, ≥ 2); AW = clog2(NREGS)
- NRD, 2, number of read ports
- NWR, 2, number of write ports; port index NWR-1 has the highest priority
- clk  in  1  clock, rising-edge active
- reset  in  1  asynchronous, active-low reset (0 = reset)
- rd_addr  in  NRD*AW  read addresses, port p at bits [p*AW +: AW]
- rd_data  out  NRD*XLEN  read data, port p at bits [p*XLEN +: XLEN]
- rd_ready  out  NRD  operand usable this cycle (not pending, or bypassed)
- wr_en  in  NWR  write enable per port
- wr_addr  in  NWR*AW  write addresses
- wr_data  in  NWR*XLEN  write data
- alloc_en  in  1  mark alloc_addr as pending (instruction with a destination issued)
- alloc_addr  in  AW  destination register being allocated
- flush  in  1  clear every pending bit (pipeline squash)
- pending  out  NREGS  scoreboard state, bit r = register r awaiting writeback

## Operation
- Storage: NREGS × XLEN flops, plus an NREGS-bit pending vector.
- Register 0: reads always return 0 with rd_ready = 1. Writes and allocations to address 0 are ignored, and pending[0] is constantly 0.
- Write: at a rising edge, for each port with wr_en = 1 and wr_addr ≠ 0, store wr_data. If several ports target the same address, the highest-indexed port wins.
- Read (combinational): rd_data[p] = wr_data of the highest-indexed port with wr_en = 1 and wr_addr = rd_addr[p] ≠ 0 (bypass hit). With no bypass hit it is the stored value.
- rd_ready[p] = 1 when rd_addr[p] = 0, or on a bypass hit, or when pending[rd_addr[p]] = 0. Otherwise it is 0.
- Scoreboard update at each rising edge, in priority order:
  1. flush = 1: all pending bits become 0. An alloc_en in the same cycle is discarded. Writes still commit to storage.
  2. Otherwise, a write on any port to register r (r ≠ 0) clears pending[r].
  3. alloc_en = 1 with alloc_addr = r ≠ 0 sets pending[r]. This overrides a same-cycle clear of the same r, because the allocation is the younger producer.
- A write to a register that is not pending is legal. It updates storage and leaves pending at 0.
- Repeated alloc to a pending register keeps it pending. There is no count: the first matching write clears it. The issue logic must not allocate a register that is still pending.
- While reset = 0: rd_data = 0 and rd_ready = all 1 on every port. Bypass is suppressed and writes and allocs are ignored.

## Timing
- Reset: asynchronous assert. All registers = 0, pending = 0, rd_data = 0, rd_ready = all 1, taking effect immediately without waiting for clk. Release is synchronous to the next rising edge. The first write is accepted at the first edge with reset = 1.
- Read latency: 0 cycles (combinational from rd_addr, wr_*, and state).
- Write latency: data is visible through bypass in the write cycle and from storage the cycle after.
- Scoreboard latency: pending[r] rises 1 cycle after the alloc edge. rd_ready for r drops in that cycle unless bypassed. It returns in the write cycle itself via bypass.
- Reset asserted mid-operation discards in-flight writes and allocs of that cycle. The state returns to the reset values.
- No combinational path from alloc_en or flush to rd_data. rd_ready depends on them only through the pending flops.

## Test plan
- Reset/zero: assert reset mid-run after writing x5 = 0xDEADBEEF → immediately rd_data = 0 and pending = 0. After release, write x0 = 0x1234 → read x0 = 0, rd_ready = 1.
- Bypass/priority: same cycle, wr port0 x7 = 0xAAAA0000 and wr port1 x7 = 0x5555FFFF, read x7 → rd_data = 0x5555FFFF in that cycle, and storage holds 0x5555FFFF next cycle.
- Scoreboard: alloc x3 at cycle n → pending[3] = 1 and rd_ready = 0 for x3 at n+1. Write x3 = 0x42 at n+3 → rd_ready = 1 with rd_data = 0x42 at n+3, and pending[3] = 0 at n+4.
- Alloc/write collision: write x9 (pending) and alloc x9 in the same cycle → pending[9] stays 1 and storage is updated.
- Flush: allocate x1, x2, x31, then flush together with alloc x4 → pending = 0 next cycle and x4 is not pending.
- Parameter sweep: NRD = 4, NWR = 1, NREGS = 16, XLEN = 64. Random writes and reads against a reference model → all ports match, and address 0 is always 0.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port integer register file: NWR write ports, NRD combinational read ports with
// writeback bypass, hardwired x0 and a per-register pending-write scoreboard.
module regfile_mp #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    parameter int NWR   = 2,
    localparam int AW   = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [NRD*AW-1:0]   i_rd_addr,
    output logic [NRD*XLEN-1:0] o_rd_data,
    output logic [NRD-1:0]      o_rd_ready,
    input  logic [NWR-1:0]      i_wr_en,
    input  logic [NWR*AW-1:0]   i_wr_addr,
    input  logic [NWR*XLEN-1:0] i_wr_data,
    input  logic                i_alloc_en,
    input  logic [AW-1:0]       i_alloc_addr,
    input  logic                i_flush,
    output logic [NREGS-1:0]    o_pending
);

    logic [XLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] r_pending;
    logic [NREGS-1:0] w_pending_nxt;

    // Ports are visited in ascending order so the highest-indexed port's NBA lands last.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int r = 0; r < NREGS; r++) r_regs[r] <= '0;
            r_pending <= '0;
        end else begin
            for (int w = 0; w < NWR; w++) begin
                if (i_wr_en[w] && (i_wr_addr[w*AW +: AW] != '0))
                    r_regs[i_wr_addr[w*AW +: AW]] <= i_wr_data[w*XLEN +: XLEN];
            end
            r_pending <= w_pending_nxt;
        end
    end

    // Alloc is applied after the write clears: it is the younger producer.
    always_comb begin
        w_pending_nxt = r_pending;
        if (i_flush) begin
            w_pending_nxt = '0;
        end else begin
            for (int w = 0; w < NWR; w++) begin
                if (i_wr_en[w]) w_pending_nxt[i_wr_addr[w*AW +: AW]] = 1'b0;
            end
            if (i_alloc_en) w_pending_nxt[i_alloc_addr] = 1'b1;
        end
        w_pending_nxt[0] = 1'b0;
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0]   w_ra;
        logic [XLEN-1:0] w_data;
        logic            w_hit;

        assign w_ra = i_rd_addr[p*AW +: AW];

        always_comb begin
            w_data = r_regs[w_ra];
            w_hit  = 1'b0;
            for (int w = 0; w < NWR; w++) begin
                if (i_wr_en[w] && (i_wr_addr[w*AW +: AW] == w_ra) && (w_ra != '0)) begin
                    w_data = i_wr_data[w*XLEN +: XLEN];
                    w_hit  = 1'b1;
                end
            end
        end

        assign o_rd_data[p*XLEN +: XLEN] = i_rst_n ? w_data : '0;
        assign o_rd_ready[p] = !i_rst_n || (w_ra == '0) || w_hit || !r_pending[w_ra];
    end

    assign o_pending = r_pending;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default 2R/2W instance plus a 4R/1W, 16x64 instance
// driven with random traffic against a simple array model.
module tb_regfile_mp;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance A: default parameters
    logic [9:0]  a_rd_addr;
    logic [63:0] a_rd_data;
    logic [1:0]  a_rd_ready;
    logic [1:0]  a_wr_en;
    logic [9:0]  a_wr_addr;
    logic [63:0] a_wr_data;
    logic        a_alloc_en;
    logic [4:0]  a_alloc_addr;
    logic        a_flush;
    logic [31:0] a_pending;

    regfile_mp u_a (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_rd_addr(a_rd_addr), .o_rd_data(a_rd_data), .o_rd_ready(a_rd_ready),
        .i_wr_en(a_wr_en), .i_wr_addr(a_wr_addr), .i_wr_data(a_wr_data),
        .i_alloc_en(a_alloc_en), .i_alloc_addr(a_alloc_addr), .i_flush(a_flush),
        .o_pending(a_pending)
    );

    // Instance B: NRD=4, NWR=1, NREGS=16, XLEN=64
    logic [15:0]  b_rd_addr;
    logic [255:0] b_rd_data;
    logic [3:0]   b_rd_ready;
    logic [0:0]   b_wr_en;
    logic [3:0]   b_wr_addr;
    logic [63:0]  b_wr_data;
    logic         b_alloc_en;
    logic [3:0]   b_alloc_addr;
    logic         b_flush;
    logic [15:0]  b_pending;

    regfile_mp #(.XLEN(64), .NREGS(16), .NRD(4), .NWR(1)) u_b (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_rd_addr(b_rd_addr), .o_rd_data(b_rd_data), .o_rd_ready(b_rd_ready),
        .i_wr_en(b_wr_en), .i_wr_addr(b_wr_addr), .i_wr_data(b_wr_data),
        .i_alloc_en(b_alloc_en), .i_alloc_addr(b_alloc_addr), .i_flush(b_flush),
        .o_pending(b_pending)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    logic [63:0] mdl [16];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        a_wr_en    = '0;
        a_alloc_en = 1'b0;
        a_flush    = 1'b0;
    endtask

    initial begin
        logic [63:0] exp_d;
        logic [3:0]  ra;
        rst_n = 1'b0;
        a_rd_addr = '0; a_wr_en = '0; a_wr_addr = '0; a_wr_data = '0;
        a_alloc_en = 1'b0; a_alloc_addr = '0; a_flush = 1'b0;
        b_rd_addr = '0; b_wr_en = '0; b_wr_addr = '0; b_wr_data = '0;
        b_alloc_en = 1'b0; b_alloc_addr = '0; b_flush = 1'b0;
        for (int r = 0; r < 16; r++) mdl[r] = '0;

        // Reset state before any clock edge
        #2;
        check("rst_rd_data", a_rd_data, 64'h0);
        check("rst_rd_ready", {62'h0, a_rd_ready}, 64'h3);
        check("rst_pending", {32'h0, a_pending}, 64'h0);

        // Bypass suppressed while in reset
        a_rd_addr = {5'd0, 5'd5};
        a_wr_en = 2'b01; a_wr_addr = {5'd0, 5'd5}; a_wr_data = {32'h0, 32'hDEADBEEF};
        a_alloc_en = 1'b1; a_alloc_addr = 5'd6;
        #1;
        check("rst_no_bypass", {32'h0, a_rd_data[31:0]}, 64'h0);

        // Release between edges; first edge with reset high accepts the write
        #5;
        rst_n = 1'b1;
        #1;
        check("bypass_x5", {32'h0, a_rd_data[31:0]}, 64'hDEADBEEF);
        tick();
        idle_a();
        #1;
        check("store_x5", {32'h0, a_rd_data[31:0]}, 64'hDEADBEEF);
        check("alloc_x6", {32'h0, a_pending}, 64'h40);

        // Async reset mid-cycle
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_rd_data", {32'h0, a_rd_data[31:0]}, 64'h0);
        check("midrst_pending", {32'h0, a_pending}, 64'h0);
        #2;
        rst_n = 1'b1;
        #1;
        check("postrst_x5", {32'h0, a_rd_data[31:0]}, 64'h0);

        // Write x0 via port 1, read x0 on port 1
        a_rd_addr = {5'd0, 5'd5};
        a_wr_en = 2'b10; a_wr_addr = {5'd0, 5'd0}; a_wr_data = {32'h1234, 32'h0};
        #1;
        check("x0_bypass_data", {32'h0, a_rd_data[63:32]}, 64'h0);
        check("x0_ready", {63'h0, a_rd_ready[1]}, 64'h1);
        tick();
        idle_a();
        #1;
        check("x0_store_data", {32'h0, a_rd_data[63:32]}, 64'h0);

        // Same-cycle writes to x7: port 1 wins
        a_rd_addr = {5'd0, 5'd7};
        a_wr_en = 2'b11; a_wr_addr = {5'd7, 5'd7}; a_wr_data = {32'h5555FFFF, 32'hAAAA0000};
        #1;
        check("prio_bypass_x7", {32'h0, a_rd_data[31:0]}, 64'h5555FFFF);
        tick();
        idle_a();
        #1;
        check("prio_store_x7", {32'h0, a_rd_data[31:0]}, 64'h5555FFFF);
        check("x7_not_pending", {32'h0, a_pending}, 64'h0);

        // Scoreboard on x3
        a_rd_addr = {5'd0, 5'd3};
        a_alloc_en = 1'b1; a_alloc_addr = 5'd3;
        #1;
        check("alloc_no_comb_path", {63'h0, a_rd_ready[0]}, 64'h1);
        tick();
        idle_a();
        #1;
        check("sb_pending3_n1", {63'h0, a_pending[3]}, 64'h1);
        check("sb_ready_n1", {63'h0, a_rd_ready[0]}, 64'h0);
        tick();
        check("sb_ready_n2", {63'h0, a_rd_ready[0]}, 64'h0);
        tick();
        a_wr_en = 2'b01; a_wr_addr = {5'd0, 5'd3}; a_wr_data = {32'h0, 32'h42};
        #1;
        check("sb_ready_n3", {63'h0, a_rd_ready[0]}, 64'h1);
        check("sb_data_n3", {32'h0, a_rd_data[31:0]}, 64'h42);
        tick();
        idle_a();
        #1;
        check("sb_pending3_n4", {63'h0, a_pending[3]}, 64'h0);
        check("sb_data_n4", {32'h0, a_rd_data[31:0]}, 64'h42);

        // Alloc/write collision on x9
        a_rd_addr = {5'd9, 5'd0};
        a_alloc_en = 1'b1; a_alloc_addr = 5'd9;
        tick();
        a_wr_en = 2'b10; a_wr_addr = {5'd9, 5'd0}; a_wr_data = {32'h99, 32'h0};
        #1;
        check("coll_ready_bypass", {63'h0, a_rd_ready[1]}, 64'h1);
        tick();
        idle_a();
        #1;
        check("coll_pending9", {63'h0, a_pending[9]}, 64'h1);
        check("coll_store_x9", {32'h0, a_rd_data[63:32]}, 64'h99);
        check("coll_ready_x9", {63'h0, a_rd_ready[1]}, 64'h0);

        // Flush with same-cycle alloc and write
        a_alloc_en = 1'b1; a_alloc_addr = 5'd1;
        tick();
        a_alloc_addr = 5'd2;
        tick();
        a_alloc_addr = 5'd31;
        tick();
        idle_a();
        #1;
        check("pre_flush_pending", {32'h0, a_pending}, 64'h80000206);
        a_flush = 1'b1; a_alloc_en = 1'b1; a_alloc_addr = 5'd4;
        a_wr_en = 2'b01; a_wr_addr = {5'd0, 5'd10}; a_wr_data = {32'h0, 32'h10};
        a_rd_addr = {5'd0, 5'd1};
        #1;
        check("flush_no_comb_path", {63'h0, a_rd_ready[0]}, 64'h0);
        tick();
        idle_a();
        a_rd_addr = {5'd0, 5'd10};
        #1;
        check("flush_pending", {32'h0, a_pending}, 64'h0);
        check("flush_write_commit", {32'h0, a_rd_data[31:0]}, 64'h10);

        // Instance B: write to x0 is never visible
        b_wr_en = 1'b1; b_wr_addr = 4'd0; b_wr_data = '1; b_rd_addr = '0;
        #1;
        for (int p = 0; p < 4; p++)
            check($sformatf("b_x0_bypass_p%0d", p), b_rd_data[p*64 +: 64], 64'h0);
        tick();
        b_wr_en = 1'b0;

        // Instance B: random traffic against the model
        for (int it = 0; it < 40; it++) begin
            b_wr_en   = 1'($urandom_range(0, 1));
            b_wr_addr = 4'($urandom_range(0, 15));
            b_wr_data = {$urandom, $urandom};
            for (int p = 0; p < 4; p++) b_rd_addr[p*4 +: 4] = 4'($urandom_range(0, 15));
            #1;
            for (int p = 0; p < 4; p++) begin
                ra = b_rd_addr[p*4 +: 4];
                exp_d = (b_wr_en[0] && b_wr_addr == ra && ra != 4'd0) ? b_wr_data : mdl[ra];
                check($sformatf("b_rd_it%0d_p%0d", it, p), b_rd_data[p*64 +: 64], exp_d);
            end
            check($sformatf("b_ready_it%0d", it), {60'h0, b_rd_ready}, 64'hF);
            tick();
            if (b_wr_en[0] && b_wr_addr != 4'd0) mdl[b_wr_addr] = b_wr_data;
        end
        b_wr_en = 1'b0;
        #1;
        check("b_pending", {48'h0, b_pending}, 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
